// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch unit.
//   fetch_state_t : fetch FSM encoding (IDLE / REQ / DROP)
//   fetch_entry_t : one prefetch buffer entry {pc, instr}
//   PC_INC        : fetch address step between sequential words
//   PCPLUS8_OFF   : offset used to build PCPlus8 from PC
// -----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] PC_INC      = 32'd4;
    localparam logic [31:0] PCPLUS8_OFF = 32'd8;

endpackage

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
// Synchronous FIFO holding fetched {pc, instr} entries.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   push, din  : write din at the tail
//   pop        : drop the head entry
//   flush      : empty the buffer; wins over push and pop in the same cycle
//   head       : entry at the head (meaningless while empty)
//   count      : number of valid entries (0..DEPTH)
//   full,empty : status flags
// DEPTH must be a power of 2 so the pointers wrap by simple overflow.
// -----------------------------------------------------------------------------
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  fetch_entry_t               din,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);
    assign head  = mem[rd_ptr];

    // A push into a full buffer is only accepted when the head leaves in
    // the same cycle, so the slot being written is always free.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed while counted valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Instruction-side producer: keeps the fetch PC, reads words from instruction
// memory over a req/ack handshake, buffers {pc, instr} pairs and presents them
// to the control unit, and redirects/flushes on PCSrc.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   PCSrc, Result       : redirect request and target (low 2 bits ignored)
//   ImemReq, ImemAddr   : memory read request and word-aligned address
//   ImemAck, ImemRData  : memory accept strobe and same-cycle read data
//   Instr, PC, PCPlus8  : head instruction, its address, address + 8
//   InstrValid          : head is valid
//   InstrReady          : consumer takes the head this cycle
//   FetchCount          : words pushed (only with FETCH_PERF_EN)
//   FlushCount          : redirects taken (only with FETCH_PERF_EN)
// Optional feature macro: FETCH_PERF_EN adds the two counters.
//
// Handshakes: memory side transfers when ImemReq && ImemAck; ImemReq and
// ImemAddr stay constant until then. Consumer side transfers when
// InstrValid && InstrReady && !PCSrc; a redirect cancels that transfer.
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCSrc,
    input  logic [31:0] Result,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemRData,
    output logic [31:0] Instr,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic [31:0] PC,
    output logic [31:0] PCPlus8
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] FlushCount
`endif
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    fetch_state_t     state;
    fetch_state_t     next_state;
    logic [31:0]      fetch_pc;
    logic [31:0]      next_pc;
    logic [31:0]      drop_addr;
    logic [31:0]      redirect_pc;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_after;
    logic             full;
    logic             empty;
    fetch_entry_t     head;
    fetch_entry_t     new_entry;

    // Misaligned targets are silently rounded down to a word boundary.
    assign redirect_pc = Result & ~32'd3;

    assign pop         = !empty && InstrReady && !PCSrc;
    assign count_after = count + 1'b1 - CNT_W'(pop);
    assign new_entry   = '{pc: fetch_pc, instr: ImemRData};

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buffer (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (PCSrc),
        .din   (new_entry),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // ---------------- FSM state and PC registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            drop_addr <= RESET_PC;
        end else begin
            state    <= next_state;
            fetch_pc <= next_pc;
            // Remember the address of the request being abandoned so it can
            // be held on the bus until memory acknowledges it.
            if (state == REQ && PCSrc && !ImemAck) drop_addr <= fetch_pc;
        end
    end

    // ---------------- FSM next state and memory outputs ----------------
    always_comb begin
        next_state = state;
        next_pc    = fetch_pc;
        ImemReq    = 1'b0;
        ImemAddr   = fetch_pc;
        push       = 1'b0;

        case (state)
            IDLE: begin
                if (PCSrc || count < DEPTH_C) next_state = REQ;
            end
            REQ: begin
                ImemReq = 1'b1;
                if (PCSrc) begin
                    // Data acked alongside a redirect belongs to the old path.
                    next_state = ImemAck ? REQ : DROP;
                end else if (ImemAck) begin
                    push       = !full || pop;
                    next_pc    = fetch_pc + PC_INC;
                    next_state = (count_after < DEPTH_C) ? REQ : IDLE;
                end
            end
            DROP: begin
                ImemReq  = 1'b1;
                ImemAddr = drop_addr;
                if (ImemAck) next_state = REQ;
            end
            default: next_state = IDLE;
        endcase

        if (PCSrc) next_pc = redirect_pc;
    end

    // ---------------- Consumer-side outputs ----------------
    // With an empty buffer PC tracks the next fetch address, which gives
    // RESET_PC out of reset and the redirect target after a flush.
    assign InstrValid = !empty;
    assign Instr      = empty ? 32'd0 : head.instr;
    assign PC         = empty ? fetch_pc : head.pc;
    assign PCPlus8    = PC + PCPLUS8_OFF;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            FetchCount <= 32'd0;
            FlushCount <= 32'd0;
        end else begin
            if (push)  FetchCount <= FetchCount + 32'd1;
            if (PCSrc) FlushCount <= FlushCount + 32'd1;
        end
    end
`endif

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction-side producer for the processor control unit.
- Holds the fetch PC and issues word reads to instruction memory over a req/ack handshake.
- Buffers returned words with their PCs and presents Instr and PCPlus8 to the controlunit/datapath with a valid/ready handshake.
- Consumes PCSrc/Result from the controlunit to redirect fetch and flush stale instructions.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset (low 2 bits must be 0).
BUF_DEPTH, 2, prefetch buffer entries; power of 2, min 2, max 8.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
PCSrc  input  1  redirect request from controlunit, sampled on clk edge
Result  input  32  redirect target, valid when PCSrc=1
ImemReq  output  1  read request to instruction memory
ImemAddr  output  32  word-aligned read address
ImemAck  input  1  memory accepts request; ImemRData valid this cycle
ImemRData  input  32  read data
Instr  output  32  instruction at buffer head
InstrValid  output  1  Instr/PC/PCPlus8 valid
InstrReady  input  1  consumer takes head this cycle
PC  output  32  address of Instr
PCPlus8  output  32  PC + 8, modulo 2^32

Behaviour:
- Reset (async): buffer empty, fetch_pc=RESET_PC, FSM=IDLE, ImemReq=0, ImemAddr=RESET_PC, InstrValid=0, Instr=0, PC=RESET_PC, PCPlus8=RESET_PC+8.
- FSM states:
  - IDLE: ImemReq=0. Go to REQ when count+0 < BUF_DEPTH; first edge after reset release always goes to REQ.
  - REQ: ImemReq=1, ImemAddr=fetch_pc, both held stable until ImemAck.
    - On ack, push {fetch_pc, ImemRData} and set fetch_pc += 4 (wraps 0xFFFF_FFFC -> 0).
    - Then stay in REQ if count after push < BUF_DEPTH, else go to IDLE.
  - DROP: redirect occurred while a request was outstanding. ImemReq stays 1 with the old address until ack; the ack data is discarded; then go to REQ at the new fetch_pc.
- At most one outstanding request. Memory latency is unbounded; zero-wait ack (same cycle as req) yields one word per cycle.
- Output side:
  - InstrValid = !empty.
  - Instr/PC come from the head entry; Instr=0 when empty. PCPlus8 = PC+8.
  - Pop on InstrValid & InstrReady & !PCSrc.
- Redirect (PCSrc=1 at an edge):
  - fetch_pc <= {Result[31:2],2'b00} (misalignment ignored).
  - Buffer flushed; InstrValid=0 next cycle.
  - A simultaneous pop, or a simultaneous ack push, is discarded.
  - If in REQ without ack this cycle -> DROP. If ack this cycle -> REQ at new target next cycle.
- Simultaneous push and pop with no redirect: count unchanged; full buffer plus pop allows an ack in the same cycle.
- Full buffer: no new request is issued, so overflow is impossible. Empty buffer with InstrReady=1: no pop, no state change.
- Reset asserted mid-request: ImemReq drops immediately (asynchronous); memory must tolerate an abandoned request.

Optional Feature:
FETCH_PERF_EN
- Defined: adds output ports FetchCount[31:0] (words pushed) and FlushCount[31:0] (redirects taken). Both reset to 0, increment by 1 per event, and wrap at 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package fetch_pkg: FSM state encoding (IDLE/REQ/DROP), entry type {pc[31:0], instr[31:0]}, constant PC_INC=4, constant PCPLUS8_OFF=8.
- Sub-module fetch_buffer: synchronous FIFO of entries with push, pop, flush, count, full, empty. Flush has priority over push and pop.
- FSM, PC logic and perf counters live in the top module.

Test Plan:
- Reset release, memory acks every cycle with ImemRData E2132000, E0822003 -> ImemAddr 0x0 then 0x4. InstrValid rises the cycle after the first ack with Instr=E2132000, PC=0, PCPlus8=8.
- InstrReady=0, ack always 1 -> exactly BUF_DEPTH words buffered, then ImemReq=0. InstrReady=1 for one cycle -> one pop and one new request, ImemAddr=0x8.
- Ack delayed 3 cycles -> ImemReq and ImemAddr held constant through all 3 wait cycles. Instr appears only after the ack.
- PCSrc=1, Result=0x0000_0103 while a request is outstanding -> DROP. Returned word discarded, next ImemAddr=0x100, InstrValid=0 until 0x100 data arrives, PC=0x100.
- PCSrc=1 in the same cycle as InstrReady and ack -> buffer empty next cycle, no pop observed, fetch restarts at the target.
- fetch_pc=0xFFFF_FFFC, instruction EAFFFFFE -> PCPlus8=0x0000_0004, next ImemAddr=0x0. With FETCH_PERF_EN, FetchCount increments per ack and FlushCount=1 after one redirect.
